// File: rtl/sme_feeder_if.sv
// Host and engine signals of the string-matching-engine feeder.
// slave = the feeder itself; master = the host/engine side that drives it.
interface sme_feeder_if;
  logic       wr_en;
  logic       wr_sel;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] str_len;
  logic [3:0] pat_len;
  logic       reuse_str;
  logic       start;
  logic       busy;
  logic       done;
  logic       start_err;
  logic       res_match;
  logic [4:0] res_index;
  logic       res_timeout;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       sme_valid;
  logic       sme_match;
  logic [4:0] sme_match_index;

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, str_len, pat_len, reuse_str, start,
    input  sme_valid, sme_match, sme_match_index,
    output busy, done, start_err, res_match, res_index, res_timeout,
    output chardata, isstring, ispattern
  );

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, str_len, pat_len, reuse_str, start,
    output sme_valid, sme_match, sme_match_index,
    input  busy, done, start_err, res_match, res_index, res_timeout,
    input  chardata, isstring, ispattern
  );
endinterface

// File: rtl/sme_feeder.sv
// Buffers one string and one pattern from the host, streams them byte-serially to the
// matcher, then waits (bounded) for its result. Engine outputs are registered.
module sme_feeder #(
  parameter int STR_DEPTH = 32,
  parameter int PAT_DEPTH = 10,
  parameter int TIMEOUT   = 1023
) (
  input  logic          clk,
  input  logic          reset,
  sme_feeder_if.slave   bus
);
  localparam int SAW = $clog2(STR_DEPTH);
  localparam int PAW = $clog2(PAT_DEPTH);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SEND_STR, SEND_PAT, WAIT, DONE} state_t;

  logic [7:0] str_mem [STR_DEPTH];
  logic [7:0] pat_mem [PAT_DEPTH];

  state_t     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [5:0] str_len_q, str_len_d;
  logic [3:0] pat_len_q, pat_len_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic       str_loaded_q, str_loaded_d;
  logic       busy_q, busy_d, done_q, done_d, start_err_q, start_err_d;
  logic       res_match_q, res_match_d, res_timeout_q, res_timeout_d;
  logic [4:0] res_index_q, res_index_d;
  logic [7:0] chardata_q, chardata_d;
  logic       isstring_q, isstring_d, ispattern_q, ispattern_d;

  logic       str_ok, pat_ok, reuse_ok, start_ok;
  logic [4:0] idx_nxt;
  logic [5:0] str_last;
  logic [4:0] pat_last;

  assign str_ok   = (bus.str_len != 6'd0) && ({1'b0, bus.str_len} <= 7'(STR_DEPTH));
  assign pat_ok   = (bus.pat_len != 4'd0) && ({1'b0, bus.pat_len} <= 5'(PAT_DEPTH));
  // A string can only be skipped if the engine actually holds one.
  assign reuse_ok = bus.reuse_str && str_loaded_q;
  assign start_ok = pat_ok && (reuse_ok || str_ok);
  assign idx_nxt  = idx_q + 5'd1;
  assign str_last = str_len_q - 6'd1;
  assign pat_last = {1'b0, pat_len_q} - 5'd1;

  // Buffer storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.wr_en) begin
      if (!bus.wr_sel && ({1'b0, bus.wr_addr} < 6'(STR_DEPTH)))
        str_mem[bus.wr_addr[SAW-1:0]] <= bus.wr_data;
      if (bus.wr_sel && ({1'b0, bus.wr_addr[3:0]} < 5'(PAT_DEPTH)))
        pat_mem[bus.wr_addr[PAW-1:0]] <= bus.wr_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    str_len_d     = str_len_q;
    pat_len_d     = pat_len_q;
    tmo_d         = tmo_q;
    str_loaded_d  = str_loaded_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    start_err_d   = 1'b0;
    res_match_d   = res_match_q;
    res_index_d   = res_index_q;
    res_timeout_d = res_timeout_q;
    chardata_d    = chardata_q;
    isstring_d    = isstring_q;
    ispattern_d   = ispattern_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (start_ok) begin
            str_len_d     = bus.str_len;
            pat_len_d     = bus.pat_len;
            busy_d        = 1'b1;
            res_match_d   = 1'b0;
            res_index_d   = 5'd0;
            res_timeout_d = 1'b0;
            idx_d         = 5'd0;
            tmo_d         = '0;
            if (reuse_ok) begin
              state_d     = SEND_PAT;
              ispattern_d = 1'b1;
              chardata_d  = pat_mem[0];
            end else begin
              state_d     = SEND_STR;
              isstring_d  = 1'b1;
              chardata_d  = str_mem[0];
            end
          end else begin
            start_err_d = 1'b1;
          end
        end
      end
      SEND_STR: begin
        if ({1'b0, idx_q} == str_last) begin
          state_d      = SEND_PAT;
          str_loaded_d = 1'b1;
          idx_d        = 5'd0;
          isstring_d   = 1'b0;
          ispattern_d  = 1'b1;
          chardata_d   = pat_mem[0];
        end else begin
          idx_d      = idx_nxt;
          chardata_d = str_mem[idx_nxt[SAW-1:0]];
        end
      end
      SEND_PAT: begin
        if (idx_q == pat_last) begin
          // Dropping both qualifiers here produces the load-terminating idle cycle.
          state_d     = WAIT;
          ispattern_d = 1'b0;
          chardata_d  = 8'd0;
          tmo_d       = '0;
        end else begin
          idx_d      = idx_nxt;
          chardata_d = pat_mem[idx_nxt[PAW-1:0]];
        end
      end
      WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (bus.sme_valid) begin
          state_d     = DONE;
          done_d      = 1'b1;
          res_match_d = bus.sme_match;
          res_index_d = bus.sme_match_index;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d       = DONE;
          done_d        = 1'b1;
          res_timeout_d = 1'b1;
          res_match_d   = 1'b0;
          res_index_d   = 5'd0;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        tmo_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      idx_q         <= 5'd0;
      str_len_q     <= 6'd0;
      pat_len_q     <= 4'd0;
      tmo_q         <= '0;
      str_loaded_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      start_err_q   <= 1'b0;
      res_match_q   <= 1'b0;
      res_index_q   <= 5'd0;
      res_timeout_q <= 1'b0;
      chardata_q    <= 8'd0;
      isstring_q    <= 1'b0;
      ispattern_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      str_len_q     <= str_len_d;
      pat_len_q     <= pat_len_d;
      tmo_q         <= tmo_d;
      str_loaded_q  <= str_loaded_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      start_err_q   <= start_err_d;
      res_match_q   <= res_match_d;
      res_index_q   <= res_index_d;
      res_timeout_q <= res_timeout_d;
      chardata_q    <= chardata_d;
      isstring_q    <= isstring_d;
      ispattern_q   <= ispattern_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.start_err   = start_err_q;
  assign bus.res_match   = res_match_q;
  assign bus.res_index   = res_index_q;
  assign bus.res_timeout = res_timeout_q;
  assign bus.chardata    = chardata_q;
  assign bus.isstring    = isstring_q;
  assign bus.ispattern   = ispattern_q;
endmodule

// File: doc/sme_feeder.md
Name: sme_feeder

Overview:
- Host-side driver for the string-matching engine: buffers one string and one pattern written by a host, then streams them byte-serially on the engine's chardata/isstring/ispattern interface.
- Waits for the engine's valid pulse, captures match/match_index, and reports a one-cycle done to the host.
- Sits between the control processor/testbench host and the matcher. It owns all sequencing of the matcher's load protocol, including the mandatory idle cycle that ends a load.

Parameters:
STR_DEPTH, 32, string buffer depth in bytes (max string length)
PAT_DEPTH, 10, pattern buffer depth in bytes (8 literal/'.' chars plus optional '^' and '$')
TIMEOUT, 1023, max cycles in WAIT before the job is aborted

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
wr_en  in  1  host buffer write strobe
wr_sel  in  1  0 = string buffer, 1 = pattern buffer
wr_addr  in  5  byte address (pattern uses low 4 bits)
wr_data  in  8  ASCII byte
str_len  in  6  string length in bytes, sampled at start
pat_len  in  4  pattern length in bytes incl. '^'/'$', sampled at start
reuse_str  in  1  sampled at start: skip string phase, engine keeps previous string
start  in  1  launch job (single-cycle pulse)
busy  out  1  high from cycle after accepted start until done cycle inclusive
done  out  1  one-cycle pulse, result valid
start_err  out  1  one-cycle pulse, start rejected
res_match  out  1  captured match
res_index  out  5  captured match_index
res_timeout  out  1  job aborted, no valid seen
chardata  out  8  byte to engine
isstring  out  1  string byte qualifier
ispattern  out  1  pattern byte qualifier
sme_valid  in  1  engine result strobe
sme_match  in  1  engine match flag
sme_match_index  in  5  engine match start index

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; str_loaded=0; length and timeout counters 0. Buffer contents are not reset.
- Buffers are written only in IDLE: wr_en=1 writes wr_data to the selected buffer at wr_addr.
  - Addresses at or above the buffer depth are dropped.
  - wr_en outside IDLE is ignored.
- start is accepted only in IDLE with 1<=str_len<=STR_DEPTH and 1<=pat_len<=PAT_DEPTH.
  - In IDLE with illegal lengths: start_err=1 for the next cycle, state stays IDLE.
  - Outside IDLE: start is ignored silently.
  - When reuse_str=1, str_len is not checked.
- Accepted start also clears res_match, res_index and res_timeout.
- FSM states: IDLE, SEND_STR, SEND_PAT, WAIT, DONE. All engine outputs are registered.
- IDLE to SEND_STR on accepted start. If reuse_str=1 and str_loaded=1, go directly to SEND_PAT. If reuse_str=1 and str_loaded=0, behave as reuse_str=0.
- SEND_STR:
  - Each cycle: isstring=1, ispattern=0, chardata=string[k], for k=0..str_len-1.
  - After the last byte, go to SEND_PAT and set str_loaded=1.
- SEND_PAT:
  - Each cycle: ispattern=1, isstring=0, chardata=pattern[k], for k=0..pat_len-1.
  - Bytes are sent verbatim, including '^' (0x5E) and '$' (0x24).
  - After the last byte, go to WAIT.
- WAIT:
  - isstring=ispattern=0 and chardata=0. The first WAIT cycle is the load-terminating idle cycle.
  - The timeout counter increments each cycle.
  - On sme_valid=1: capture sme_match to res_match and sme_match_index to res_index, then go to DONE.
  - When the counter reaches TIMEOUT without sme_valid: res_timeout=1, res_match=0, res_index=0, then go to DONE.
  - If sme_valid and the timeout terminal count occur in the same cycle, the valid result wins.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. Results hold until the next accepted start.
- sme_valid seen outside WAIT is ignored.
- isstring and ispattern are never high together. No gap cycles within or between phases.
- Latency: start at cycle T gives the first engine byte at T+1.
  - First WAIT cycle at T+1+S+P, where S = str_len (0 if reused) and P = pat_len.
  - done occurs 1 cycle after sme_valid is sampled.
- If reset is asserted mid-job, the engine outputs drop to 0 immediately. The host must also reset the engine.

Test Plan:
- String "hello world" (11 bytes), pattern "wor" (3), start -> isstring high for 11 cycles from T+1, ispattern high for 3 cycles, then 0. Engine responds valid, match=1, index=6 -> res_match=1, res_index=6, done 1 cycle later, busy drops after done.
- reuse_str=1 after a prior job, pattern "^h.l" (4) -> no isstring cycles; ispattern from T+1 for 4 cycles with bytes 0x5E,'h','.','l' verbatim.
- reuse_str=1 immediately after reset -> full string phase is sent.
- start with str_len=0, then pat_len=11, then str_len=33 -> start_err pulses each time, busy stays 0, no engine traffic.
- Engine model never asserts valid -> after TIMEOUT cycles in WAIT: res_timeout=1, res_match=0, done=1. Separately, sme_valid coincident with terminal count -> res_timeout=0 and the result is captured.
- Async reset low during SEND_PAT -> isstring, ispattern, busy and done are 0 without a clock edge; after release, wr_en in IDLE works and start with the old buffers resends the same bytes.
